// File: rtl/hazard_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module  : arm_pipe_pkg
// Purpose : Shared types and constants for the 64-bit ARM pipeline hazard
//           scoreboard: in-flight entry record, forward-select encoding and
//           names for the tracked pipeline positions.
// Ports   : none (package)
// Config  : none
// Revision: 1.0  initial release
// ============================================================================
package arm_pipe_pkg;

  // Register-index storage width inside an entry. It is wider than any
  // realistic REGW so one packed record serves every parametrisation; indices
  // are zero-extended on the way in and compared at full width.
  localparam int RD_MAXW = 8;

  // fwd_sel value meaning "read the register file, no forwarding".
  localparam int FWD_REGFILE = 0;

  // Tracked positions after decode.
  localparam int POS_EX  = 0;
  localparam int POS_MEM = 1;
  localparam int POS_WB  = 2;

  // One in-flight instruction. valid=1 only for a real register writer.
  typedef struct packed {
    logic               valid;
    logic [RD_MAXW-1:0] rd;
    logic               is_load;
  } entry_t;

endpackage
`default_nettype wire

// File: rtl/hazard_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module  : hazard_scoreboard_if
// Purpose : Decode-side bundle between the IF/ID stage and the hazard
//           scoreboard.
// Ports   : master - decode stage: drives id_*, flush, ext_stall;
//                    receives stall, issue, fwd_sel_a/b, pending
//           slave  - scoreboard: the mirror image
// Config  : none
// Revision: 1.0  initial release
// ============================================================================
interface hazard_scoreboard_if #(
  parameter int REGW = 5,
  parameter int FWDW = 2
);
  logic            id_valid;
  logic [REGW-1:0] id_rs_a;
  logic [REGW-1:0] id_rs_b;
  logic            id_use_a;
  logic            id_use_b;
  logic [REGW-1:0] id_rd;
  logic            id_rd_wr;
  logic            id_is_load;
  logic            flush;
  logic            ext_stall;
  logic            stall;
  logic            issue;
  logic [FWDW-1:0] fwd_sel_a;
  logic [FWDW-1:0] fwd_sel_b;
  logic [FWDW-1:0] pending;

  modport master (
    output id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b,
           id_rd, id_rd_wr, id_is_load, flush, ext_stall,
    input  stall, issue, fwd_sel_a, fwd_sel_b, pending
  );

  modport slave (
    input  id_valid, id_rs_a, id_rs_b, id_use_a, id_use_b,
           id_rd, id_rd_wr, id_is_load, flush, ext_stall,
    output stall, issue, fwd_sel_a, fwd_sel_b, pending
  );
endinterface
`default_nettype wire

// File: rtl/hazard_scoreboard_match.sv
`default_nettype none
// ============================================================================
// Module  : hazard_match
// Purpose : Compares one decode source operand against every tracked entry.
//           Reports whether any older writer matches and, when forwarding is
//           built in, the youngest matching position (as a forward select)
//           and whether that youngest match is a load still in EX.
// Ports   : i_entries  - tracked entries, index 0 = EX (youngest)
//           i_rs       - source register index
//           i_use      - the instruction really reads i_rs
//           o_hit      - some valid entry writes i_rs
//           o_pos      - (FORWARDING_EN) 0 = regfile, k = position k-1
//           o_load_use - (FORWARDING_EN) youngest match is a load at EX
// Config  : FORWARDING_EN enables the priority/forwarding outputs
// Revision: 1.0  initial release
// ============================================================================
module hazard_match
  import arm_pipe_pkg::*;
#(
  parameter int STAGES   = 3,
  parameter int REGW     = 5,
  parameter int ZERO_REG = 31
`ifdef FORWARDING_EN
  ,
  parameter int FWDW     = 2
`endif
) (
  input  entry_t [STAGES-1:0] i_entries,
  input  logic   [REGW-1:0]   i_rs,
  input  logic                i_use,
  output logic                o_hit
`ifdef FORWARDING_EN
  ,
  output logic   [FWDW-1:0]   o_pos,
  output logic                o_load_use
`endif
);

  logic               w_src_live;
  logic [RD_MAXW-1:0] w_rs_ext;
  logic [STAGES-1:0]  w_match;

  // The zero register never creates a dependency.
  assign w_src_live = i_use && (i_rs != REGW'(ZERO_REG));
  assign w_rs_ext   = RD_MAXW'(i_rs);

  for (genvar p = 0; p < STAGES; p++) begin : g_cmp
    assign w_match[p] = w_src_live && i_entries[p].valid &&
                        (i_entries[p].rd == w_rs_ext);
  end

  assign o_hit = |w_match;

`ifdef FORWARDING_EN
  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    o_pos = FWDW'(FWD_REGFILE);
    for (int p = STAGES - 1; p >= 0; p--) begin
      if (w_match[p]) begin
        o_pos = FWDW'(p + 1);
      end
    end
  end

  // A load in EX has no result yet, so it cannot forward.
  assign o_load_use = w_match[POS_EX] && i_entries[POS_EX].is_load;
`endif

endmodule
`default_nettype wire

// File: rtl/hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : hazard_scoreboard
// Purpose : Data-hazard scoreboard beside the IF/ID stage. Tracks the
//           destination of every instruction in the STAGES positions after
//           decode and decides per source operand whether decode stalls or
//           which stage forwards the value.
// Ports   : clk    - rising-edge clock
//           reset  - synchronous, active-high; clears all entries
//           sb     - hazard_scoreboard_if.slave:
//                    in : id_valid, id_rs_a/b, id_use_a/b, id_rd, id_rd_wr,
//                         id_is_load, flush, ext_stall
//                    out: stall, issue, fwd_sel_a/b, pending
// Config  : FORWARDING_EN - defined: forward from EX/MEM/WB, stall only on
//                           load-use; undefined: fwd_sel tied to 0, any
//                           in-flight writer of a used source stalls
// Revision: 1.0  initial release
// ============================================================================
module hazard_scoreboard
  import arm_pipe_pkg::*;
#(
  parameter int NREGS    = 32,
  parameter int REGW     = 5,
  parameter int STAGES   = 3,
  parameter int ZERO_REG = 31,
  parameter int FWDW     = $clog2(STAGES + 1)
) (
  input  logic                clk,
  input  logic                reset,
  hazard_scoreboard_if.slave  sb
);

  if (REGW != $clog2(NREGS)) begin : g_bad_regw
    $error("hazard_scoreboard: REGW must equal clog2(NREGS)");
  end

  entry_t [STAGES-1:0] r_entries;
  entry_t              w_new;

  logic w_hit_a;
  logic w_hit_b;
  logic w_hazard_a;
  logic w_hazard_b;
  logic w_active;
  logic w_stall;
  logic w_issue;

`ifdef FORWARDING_EN
  logic [FWDW-1:0] w_pos_a;
  logic [FWDW-1:0] w_pos_b;
  logic            w_load_use_a;
  logic            w_load_use_b;
`endif

  // Matching looks only at registered entries, i.e. strictly older
  // instructions, so an instruction whose rd equals its own source never
  // stalls on itself.
  hazard_match #(
    .STAGES   (STAGES),
    .REGW     (REGW),
    .ZERO_REG (ZERO_REG)
`ifdef FORWARDING_EN
    ,
    .FWDW     (FWDW)
`endif
  ) u_match_a (
    .i_entries  (r_entries),
    .i_rs       (sb.id_rs_a),
    .i_use      (sb.id_use_a),
    .o_hit      (w_hit_a)
`ifdef FORWARDING_EN
    ,
    .o_pos      (w_pos_a),
    .o_load_use (w_load_use_a)
`endif
  );

  hazard_match #(
    .STAGES   (STAGES),
    .REGW     (REGW),
    .ZERO_REG (ZERO_REG)
`ifdef FORWARDING_EN
    ,
    .FWDW     (FWDW)
`endif
  ) u_match_b (
    .i_entries  (r_entries),
    .i_rs       (sb.id_rs_b),
    .i_use      (sb.id_use_b),
    .o_hit      (w_hit_b)
`ifdef FORWARDING_EN
    ,
    .o_pos      (w_pos_b),
    .o_load_use (w_load_use_b)
`endif
  );

`ifdef FORWARDING_EN
  assign w_hazard_a   = w_load_use_a;
  assign w_hazard_b   = w_load_use_b;
  assign sb.fwd_sel_a = w_pos_a;
  assign sb.fwd_sel_b = w_pos_b;
  // w_hit_* is implied by a non-zero forward select; kept for symmetry.
  logic w_unused_hits;
  assign w_unused_hits = w_hit_a ^ w_hit_b;
`else
  assign w_hazard_a   = w_hit_a;
  assign w_hazard_b   = w_hit_b;
  assign sb.fwd_sel_a = FWDW'(FWD_REGFILE);
  assign sb.fwd_sel_b = FWDW'(FWD_REGFILE);
`endif

  // Flush kills the decode instruction, so its hazards are irrelevant.
  assign w_active = sb.id_valid && !sb.flush;
  assign w_stall  = sb.ext_stall || (w_active && (w_hazard_a || w_hazard_b));
  assign w_issue  = w_active && !w_stall;

  assign sb.stall = w_stall;
  assign sb.issue = w_issue;

  // Only real writers are recorded; everything else becomes a bubble so the
  // stored rd of a dead slot can never produce a false match.
  always_comb begin
    w_new         = '0;
    w_new.valid   = w_issue && sb.id_rd_wr && (sb.id_rd != REGW'(ZERO_REG));
    if (w_new.valid) begin
      w_new.rd      = RD_MAXW'(sb.id_rd);
      w_new.is_load = sb.id_is_load;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_entries <= '0;
    end else if (!sb.ext_stall) begin
      r_entries[0] <= w_new;
      for (int p = 1; p < STAGES; p++) begin
        r_entries[p] <= r_entries[p-1];
      end
    end
  end

  // Popcount of the registered entries; tracks the shift by construction.
  always_comb begin
    sb.pending = '0;
    for (int p = 0; p < STAGES; p++) begin
      sb.pending = sb.pending + FWDW'(r_entries[p].valid);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_hazard_scoreboard.sv
`default_nettype none
// ============================================================================
// Module  : tb_hazard_scoreboard
// Purpose : Directed self-checking bench for hazard_scoreboard. Expected
//           values follow the FORWARDING_EN setting of the build.
// Revision: 1.0  initial release
// ============================================================================
module tb_hazard_scoreboard;

  logic clk;
  logic reset;
  int   n_pass;
  int   n_total;

  hazard_scoreboard_if #(.REGW(5), .FWDW(2)) sb_if ();

  hazard_scoreboard #(
    .NREGS    (32),
    .REGW     (5),
    .STAGES   (3),
    .ZERO_REG (31),
    .FWDW     (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .sb    (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    sb_if.id_valid   = 1'b0;
    sb_if.id_rs_a    = '0;
    sb_if.id_rs_b    = '0;
    sb_if.id_use_a   = 1'b0;
    sb_if.id_use_b   = 1'b0;
    sb_if.id_rd      = '0;
    sb_if.id_rd_wr   = 1'b0;
    sb_if.id_is_load = 1'b0;
    sb_if.flush      = 1'b0;
    sb_if.ext_stall  = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [4:0] ra, input logic ua,
                       input logic [4:0] rb, input logic ub,
                       input logic [4:0] rd, input logic wr, input logic ld);
    sb_if.id_valid   = v;
    sb_if.id_rs_a    = ra;
    sb_if.id_use_a   = ua;
    sb_if.id_rs_b    = rb;
    sb_if.id_use_b   = ub;
    sb_if.id_rd      = rd;
    sb_if.id_rd_wr   = wr;
    sb_if.id_is_load = ld;
    #1;
  endtask

  task automatic do_reset();
    set_idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (sb_if.pending !== 2'd0) $display("FAIL reset_pending: got %0d required 0", sb_if.pending);
    else n_pass++;
    n_total++;
    if (sb_if.stall !== 1'b0) $display("FAIL reset_stall: got %0b required 0", sb_if.stall);
    else n_pass++;
    n_total++;
    if (sb_if.fwd_sel_a !== 2'd0 || sb_if.fwd_sel_b !== 2'd0)
      $display("FAIL reset_fwd: got %0d/%0d required 0/0", sb_if.fwd_sel_a, sb_if.fwd_sel_b);
    else n_pass++;
    // Three independent writers fill the scoreboard.
    drive(1, 0, 0, 0, 0, 5'd10, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 5'd11, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 5'd12, 1, 0); tick();
    set_idle(); #1;
    n_total++;
    if (sb_if.pending !== 2'd3) $display("FAIL fill_pending: got %0d required 3", sb_if.pending);
    else n_pass++;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_total++;
    if (sb_if.pending !== 2'd0) $display("FAIL midreset_pending: got %0d required 0", sb_if.pending);
    else n_pass++;
  endtask

  task automatic test_raw_alu();
    do_reset();
    drive(1, 0, 0, 0, 0, 5'd1, 1, 0);          // ADD X1
    n_total++;
    if (sb_if.issue !== 1'b1) $display("FAIL alu_first_issue: got %0b required 1", sb_if.issue);
    else n_pass++;
    tick();
    drive(1, 5'd1, 1, 5'd3, 1, 5'd2, 1, 0);    // SUB X2,X1,X3
`ifdef FORWARDING_EN
    n_total++;
    if (sb_if.stall !== 1'b0 || sb_if.issue !== 1'b1)
      $display("FAIL alu_fwd_stall: got stall=%0b issue=%0b required 0/1", sb_if.stall, sb_if.issue);
    else n_pass++;
    n_total++;
    if (sb_if.fwd_sel_a !== 2'd1 || sb_if.fwd_sel_b !== 2'd0)
      $display("FAIL alu_fwd_sel: got %0d/%0d required 1/0", sb_if.fwd_sel_a, sb_if.fwd_sel_b);
    else n_pass++;
`else
    for (int c = 0; c < 3; c++) begin
      n_total++;
      if (sb_if.stall !== 1'b1 || sb_if.issue !== 1'b0 || sb_if.fwd_sel_a !== 2'd0)
        $display("FAIL alu_stall_c%0d: got stall=%0b issue=%0b fwd=%0d required 1/0/0",
                 c, sb_if.stall, sb_if.issue, sb_if.fwd_sel_a);
      else n_pass++;
      tick();
    end
    n_total++;
    if (sb_if.stall !== 1'b0 || sb_if.issue !== 1'b1)
      $display("FAIL alu_release: got stall=%0b issue=%0b required 0/1", sb_if.stall, sb_if.issue);
    else n_pass++;
`endif
    tick();
    set_idle();
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 0, 0, 0, 0, 5'd4, 1, 1);          // LDR X4
    tick();
    drive(1, 5'd4, 1, 5'd4, 1, 5'd5, 1, 0);    // ADD X5,X4,X4
`ifdef FORWARDING_EN
    n_total++;
    if (sb_if.stall !== 1'b1 || sb_if.issue !== 1'b0)
      $display("FAIL lu_stall: got stall=%0b issue=%0b required 1/0", sb_if.stall, sb_if.issue);
    else n_pass++;
    tick();
    n_total++;
    if (sb_if.stall !== 1'b0 || sb_if.issue !== 1'b1)
      $display("FAIL lu_release: got stall=%0b issue=%0b required 0/1", sb_if.stall, sb_if.issue);
    else n_pass++;
    n_total++;
    if (sb_if.fwd_sel_a !== 2'd2 || sb_if.fwd_sel_b !== 2'd2)
      $display("FAIL lu_fwd: got %0d/%0d required 2/2", sb_if.fwd_sel_a, sb_if.fwd_sel_b);
    else n_pass++;
`else
    for (int c = 0; c < 3; c++) begin
      n_total++;
      if (sb_if.stall !== 1'b1 || sb_if.issue !== 1'b0)
        $display("FAIL lu_stall_c%0d: got stall=%0b issue=%0b required 1/0", c, sb_if.stall, sb_if.issue);
      else n_pass++;
      tick();
    end
    n_total++;
    if (sb_if.issue !== 1'b1 || sb_if.fwd_sel_a !== 2'd0 || sb_if.fwd_sel_b !== 2'd0)
      $display("FAIL lu_release: got issue=%0b fwd=%0d/%0d required 1/0/0",
               sb_if.issue, sb_if.fwd_sel_a, sb_if.fwd_sel_b);
    else n_pass++;
`endif
    tick();
    set_idle();
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive(1, 0, 0, 0, 0, 5'd31, 1, 0);         // ADD X31
    tick();
    drive(1, 5'd31, 1, 5'd31, 1, 5'd8, 1, 0);  // reads X31 twice
    n_total++;
    if (sb_if.pending !== 2'd0) $display("FAIL zr_pending: got %0d required 0", sb_if.pending);
    else n_pass++;
    n_total++;
    if (sb_if.stall !== 1'b0 || sb_if.issue !== 1'b1 || sb_if.fwd_sel_a !== 2'd0)
      $display("FAIL zr_read: got stall=%0b issue=%0b fwd=%0d required 0/1/0",
               sb_if.stall, sb_if.issue, sb_if.fwd_sel_a);
    else n_pass++;
    tick();
    set_idle();
  endtask

  task automatic test_youngest();
    do_reset();
    drive(1, 0, 0, 0, 0, 5'd6, 1, 0); tick();  // ADD X6
    drive(1, 0, 0, 0, 0, 5'd6, 1, 0); tick();  // ADD X6 again
    drive(1, 5'd6, 1, 0, 0, 5'd9, 1, 0);       // reader of X6
    n_total++;
    if (sb_if.pending !== 2'd2) $display("FAIL yg_pending: got %0d required 2", sb_if.pending);
    else n_pass++;
`ifdef FORWARDING_EN
    n_total++;
    if (sb_if.fwd_sel_a !== 2'd1 || sb_if.stall !== 1'b0)
      $display("FAIL yg_fwd: got fwd=%0d stall=%0b required 1/0", sb_if.fwd_sel_a, sb_if.stall);
    else n_pass++;
`else
    n_total++;
    if (sb_if.stall !== 1'b1 || sb_if.fwd_sel_a !== 2'd0)
      $display("FAIL yg_stall: got stall=%0b fwd=%0d required 1/0", sb_if.stall, sb_if.fwd_sel_a);
    else n_pass++;
`endif
    set_idle();
  endtask

  task automatic test_flush();
    do_reset();
    drive(1, 0, 0, 0, 0, 5'd7, 1, 1); tick();  // LDR X7 (hazard in both builds)
    sb_if.flush = 1'b1;
    drive(1, 5'd7, 1, 0, 0, 5'd8, 1, 0);
    n_total++;
    if (sb_if.issue !== 1'b0 || sb_if.stall !== 1'b0)
      $display("FAIL flush_ctl: got issue=%0b stall=%0b required 0/0", sb_if.issue, sb_if.stall);
    else n_pass++;
    tick();
    n_total++;
    if (sb_if.pending !== 2'd1) $display("FAIL flush_pending: got %0d required 1", sb_if.pending);
    else n_pass++;
    set_idle();
  endtask

  task automatic test_ext_stall();
    do_reset();
    drive(1, 0, 0, 0, 0, 5'd8, 1, 0); tick();
    drive(1, 0, 0, 0, 0, 5'd9, 1, 0); tick();
    sb_if.ext_stall = 1'b1;
    drive(1, 5'd9, 1, 0, 0, 5'd10, 1, 0);
    n_total++;
    if (sb_if.stall !== 1'b1 || sb_if.issue !== 1'b0)
      $display("FAIL es_ctl: got stall=%0b issue=%0b required 1/0", sb_if.stall, sb_if.issue);
    else n_pass++;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_total++;
      if (sb_if.pending !== 2'd2) $display("FAIL es_hold_c%0d: got %0d required 2", c, sb_if.pending);
      else n_pass++;
`ifdef FORWARDING_EN
      n_total++;
      if (sb_if.fwd_sel_a !== 2'd1) $display("FAIL es_pos_c%0d: got %0d required 1", c, sb_if.fwd_sel_a);
      else n_pass++;
`endif
    end
    set_idle(); #1;
    tick();
    n_total++;
    if (sb_if.pending !== 2'd2) $display("FAIL es_shift1: got %0d required 2", sb_if.pending);
    else n_pass++;
    tick();
    n_total++;
    if (sb_if.pending !== 2'd1) $display("FAIL es_shift2: got %0d required 1", sb_if.pending);
    else n_pass++;
    tick();
    n_total++;
    if (sb_if.pending !== 2'd0) $display("FAIL es_shift3: got %0d required 0", sb_if.pending);
    else n_pass++;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;
    reset   = 1'b1;
    set_idle();
    tick();
    test_reset();
    test_raw_alu();
    test_load_use();
    test_zero_reg();
    test_youngest();
    test_flush();
    test_ext_stall();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
